// File: rtl/qs_onset_l3.sv
// Level-3 Q-onset / S-end locator: backward scan of a small history buffer from
// the R peak for the Q onset, concurrent forward search over SW samples for the S end.
module qs_onset_l3 #(
    parameter int QW = 16,
    parameter int SW = 24
) (
    input  logic               clk,
    input  logic               nReset,
    input  logic signed [15:0] data_in,
    input  logic               data_valid,
    input  logic               r_peak_flag,
    input  logic        [15:0] thr,
    output logic        [15:0] q_begin_l3,
    output logic               q_begin_l3_flag,
    output logic               qwindow1_full,
    output logic        [15:0] s_end_l3,
    output logic               s_end_l3_flag,
    output logic               swindow1_full,
    output logic               busy,
    output logic               beat_done
);
    localparam int QAW = $clog2(QW);

    typedef enum logic {IDLE, QSCAN} state_t;

    state_t         state_q;
    logic [15:0]    idx_q;
    logic [15:0]    r_pos_q;
    logic [QAW:0]   fill_q;
    logic [QAW-1:0] n_q;
    logic [QAW-1:0] k_q;
    logic [7:0]     s_cnt_q;
    logic           s_act_q;
    logic [15:0]    rd_mag_q;
    logic [15:0]    mem [QW];

    logic [15:0]    din_u;
    logic [15:0]    mag;
    logic           in_scan;
    logic           accept;
    logic           q_hit;
    logic           q_end;
    logic           s_step;
    logic           s_hit;
    logic           s_last;
    logic           busy_d;
    logic [QAW-1:0] n_d;
    logic [QAW-1:0] rd_addr;

    // -32768 has no positive counterpart and saturates to 32767
    assign din_u   = data_in;
    assign mag     = din_u[15] ? ((din_u == 16'h8000) ? 16'h7fff : (~din_u + 16'd1)) : din_u;

    assign in_scan = (state_q == QSCAN);
    assign accept  = data_valid & r_peak_flag & ~busy;
    assign n_d     = (fill_q >= (QAW+1)'(QW-1)) ? QAW'(QW-1) : fill_q[QAW-1:0];

    assign q_hit   = in_scan & (n_q != '0) & (rd_mag_q < thr);
    assign q_end   = in_scan & ((n_q == '0) | q_hit | (k_q == n_q));

    assign s_step  = s_act_q & data_valid;
    assign s_hit   = s_step & ~s_end_l3_flag & (mag < thr);
    assign s_last  = s_step & (s_cnt_q == 8'(SW - 1));

    assign busy_d  = accept | (in_scan & ~q_end) | (s_act_q & ~s_last);

    // Read is issued one cycle ahead: predecessor k is fetched while k-1 is examined
    assign rd_addr = QAW'(accept ? (idx_q - 16'd1) : (r_pos_q - 16'(k_q) - 16'd1));

    always_ff @(posedge clk) begin
        if (data_valid && !in_scan) begin
            mem[idx_q[QAW-1:0]] <= mag;
        end
        rd_mag_q <= mem[rd_addr];
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            r_pos_q         <= '0;
            fill_q          <= '0;
            n_q             <= '0;
            k_q             <= '0;
            s_cnt_q         <= '0;
            s_act_q         <= 1'b0;
            q_begin_l3      <= '0;
            q_begin_l3_flag <= 1'b0;
            qwindow1_full   <= 1'b0;
            s_end_l3        <= '0;
            s_end_l3_flag   <= 1'b0;
            swindow1_full   <= 1'b0;
            busy            <= 1'b0;
            beat_done       <= 1'b0;
        end else begin
            busy      <= busy_d;
            beat_done <= busy & ~busy_d;

            if (data_valid) begin
                idx_q <= idx_q + 16'd1;
            end
            if (data_valid && !in_scan && fill_q != (QAW+1)'(QW)) begin
                fill_q <= fill_q + (QAW+1)'(1);
            end

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q         <= QSCAN;
                        r_pos_q         <= idx_q;
                        n_q             <= n_d;
                        k_q             <= QAW'(1);
                        q_begin_l3_flag <= 1'b0;
                        qwindow1_full   <= 1'b0;
                        s_end_l3_flag   <= 1'b0;
                        swindow1_full   <= 1'b0;
                        s_cnt_q         <= '0;
                        s_act_q         <= 1'b1;
                    end
                end
                QSCAN: begin
                    if (q_hit) begin
                        q_begin_l3      <= r_pos_q - 16'(k_q);
                        q_begin_l3_flag <= 1'b1;
                    end
                    // History restarts after every scan, so the next beat only sees fresh samples
                    if (q_end) begin
                        state_q       <= IDLE;
                        qwindow1_full <= (n_q == QAW'(QW-1));
                        fill_q        <= '0;
                    end else begin
                        k_q <= k_q + QAW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (s_step) begin
                s_cnt_q <= s_cnt_q + 8'd1;
                if (s_hit) begin
                    s_end_l3      <= idx_q;
                    s_end_l3_flag <= 1'b1;
                end
                if (s_last) begin
                    swindow1_full <= 1'b1;
                    s_act_q       <= 1'b0;
                end
            end
        end
    end
endmodule

// File: doc/qs_onset_l3.md
# qs_onset_l3

Level-3 Q-onset / S-end locator for the QRS delineation chain. Consumes the decimated level-3 wavelet coefficient stream plus an R-peak marker. Searches backward from R for the Q onset and forward from R for the S end. Delivers level-3 sample indices, found-flags and window-complete flags to the refinement stage, which scales them to full-rate positions.

## Interface
Parameters:
- QW, 16: Q look-back buffer depth in samples, power of 2, ≥4; the scan covers at most QW-1 predecessors of R.
- SW, 24: S look-ahead window length in samples after R, 1..255.

Ports:
- clk  in  1  system clock.
- nReset  in  1  asynchronous, active-low reset.
- data_in  in  16  signed level-3 coefficient.
- data_valid  in  1  qualifies data_in; at most one sample per cycle.
- r_peak_flag  in  1  marks the sample presented with data_valid as the R peak; ignored without data_valid.
- thr  in  16  unsigned magnitude threshold.
- q_begin_l3  out  16  level-3 index of the Q onset.
- q_begin_l3_flag  out  1  Q onset found for the current beat.
- qwindow1_full  out  1  Q scan completed over a full window of QW-1 predecessors.
- s_end_l3  out  16  level-3 index of the S end.
- s_end_l3_flag  out  1  S end found for the current beat.
- swindow1_full  out  1  SW post-R samples examined.
- busy  out  1  Q scan or S search in progress.
- beat_done  out  1  one-cycle pulse when both searches finish.

## Operation
- Sample index idx: 16-bit, reset 0. The first valid sample is index 0. Increments on each data_valid and wraps 65535→0. All index arithmetic is mod 2^16.
- |x| = abs(data_in). -32768 saturates to 32767. A hit is |x| < thr, strict and unsigned. thr=0 never hits.
- Circular buffer of QW entries. Writes on data_valid when the state is not QSCAN. fill counter saturates at QW.
- Q FSM: IDLE → QSCAN → IDLE.
  - Acceptance: when busy=0 and data_valid & r_peak_flag, the R sample is accepted.
  - On acceptance: latch r_pos=idx and n=min(fill,QW-1); clear both found-flags, both full-flags and the S counter.
  - The R sample itself is written to the buffer, but it is never tested as Q.
  - QSCAN examines predecessor k = 1..n, one per cycle, from nearest to farthest.
  - At the first hit: q_begin_l3 = r_pos-k, q_begin_l3_flag=1, scan ends.
  - The scan also ends after k=n.
  - At scan end: qwindow1_full=1 iff n=QW-1, whether or not there was a hit. fill is cleared to 0.
  - n=0 means QSCAN lasts one cycle with no hit.
  - Samples arriving during QSCAN are not buffered but are processed by the S search.
- S search runs concurrently with QSCAN and starts with the sample after R.
  - On each data_valid: s_cnt++.
  - If not yet found and hit: s_end_l3 = that sample's idx, s_end_l3_flag=1.
  - When s_cnt=SW: swindow1_full=1 and the S search is done.
- Miss behaviour: q_begin_l3 and s_end_l3 hold their previous values; the flag stays 0.
- busy = QSCAN | S not done.
- beat_done pulses in the cycle after the later of the two searches completes.
- Any r_peak_flag while busy=1 is ignored; the sample is still processed as data.
- Outputs hold until the next accepted R.
- Reset value 0 for every output, idx, fill, s_cnt and state. Reset mid-operation aborts both searches; buffer contents are discarded.

## Timing
- All outputs are registered.
- R accepted at edge t: flags clear and busy=1 visible after edge t.
- Predecessor k is examined in the cycle after edge t+k-1. A Q hit is visible after edge t+k.
- qwindow1_full is visible after edge t+n, or at the hit edge.
- S hit on the j-th post-R sample: s_end_l3 and flag are visible one edge after that sample's data_valid.
- swindow1_full is visible one edge after the SW-th post-R sample.
- Minimum Q latency is 1 cycle; maximum is QW-1 cycles.
- Latency is independent of data_valid gaps for Q and dependent on them for S.
- Wrap: r_pos=2 with hit at k=5 gives q_begin_l3=65533.

## Test plan
- Ramp: 20 samples with |x|=100, then samples 20..39 with |x|=10, thr=50, R at idx 40, QW=16 → q_begin_l3=39, q flag=1, qwindow1_full=1 after 1 cycle.
- No Q hit: all |x|=1000, R at idx 40 → q flag=0, q_begin_l3 unchanged, qwindow1_full=1 after 15 cycles.
- Short history: R at idx 5 with no hit → scan of 5 cycles, qwindow1_full=0.
- S window: R at idx 100 and post-R samples 1..6 with |x|=200, sample 7 with |x|=3, thr=50 → s_end_l3=107, s flag=1, swindow1_full=1 after the 24th post-R sample, then beat_done pulse.
- Back-to-back R: second R at R+10 while busy → ignored, outputs unchanged. R after beat_done is accepted and the flags clear.
- Edge cases:
  - data_in=-32768 with thr=32767 → no hit.
  - nReset asserted mid-QSCAN → all outputs 0 immediately; an R right after deassert sees n=0.
